// File: rtl/csr_gpio_bank.sv
// CSR-mapped GPIO bank: registered outputs, synchronised + debounced inputs.
// Define GPIO_IRQ_EN to add the IE/PEND/EDGE registers, edge detection and irq.
module csr_gpio_bank #(
  parameter int          IN_COUNT  = 8,
  parameter int          OUT_COUNT = 8,
  parameter logic [11:0] BASE_ADDR = 12'hBC4,
  parameter int          TICK_DIV  = 200_000,
  parameter logic [31:0] OUT_RESET = 32'h0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 read,
  input  logic [2:0]           modify,
  input  logic [31:0]          wdata,
  input  logic [11:0]          addr,
  output logic [31:0]          rdata,
  output logic                 valid,
  input  logic [IN_COUNT-1:0]  inpins,
  output logic [OUT_COUNT-1:0] outpins,
  output logic                 irq
);

  localparam int CNT_W = $clog2(TICK_DIV);

  function automatic logic [31:0] apply_mod(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [2:0]  m);
    apply_mod = old;
    if (m[0])      apply_mod = wd;
    else if (m[1]) apply_mod = old | wd;
    else if (m[2]) apply_mod = old & ~wd;
  endfunction

  logic [11:0]          off;
  logic                 access;
  logic                 hit;
  logic [31:0]          rd_hit;
  logic [OUT_COUNT-1:0] out_q, out_nxt;
  logic [IN_COUNT-1:0]  sync_p0, sync_p1;
  logic [IN_COUNT-1:0]  hist_p0, hist_p1;
  logic [IN_COUNT-1:0]  in_q, in_nxt, stable;
  logic [CNT_W-1:0]     cnt_q;
  logic                 tick;

  assign off     = addr - BASE_ADDR;
  assign access  = read | (|modify);
  assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
  // A bit is stable when the new sample matches both history samples.
  assign stable  = ~(sync_p1 ^ hist_p0) & ~(sync_p1 ^ hist_p1);
  assign in_nxt  = tick ? ((stable & sync_p1) | (~stable & in_q)) : in_q;
  assign out_nxt = ((off == 12'd0) && (|modify))
                   ? OUT_COUNT'(apply_mod(32'(out_q), wdata, modify)) : out_q;
  assign outpins = out_q;

  // Stage p0 -> p1: two-flop synchroniser, then tick-sampled debounce history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q   <= OUT_RESET[OUT_COUNT-1:0];
      sync_p0 <= '0;
      sync_p1 <= '0;
      hist_p0 <= '0;
      hist_p1 <= '0;
      in_q    <= '0;
      cnt_q   <= '0;
    end else begin
      out_q   <= out_nxt;
      sync_p0 <= inpins;
      sync_p1 <= sync_p0;
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        hist_p0 <= sync_p1;
        hist_p1 <= hist_p0;
      end
      in_q    <= in_nxt;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [IN_COUNT-1:0] ie_q, pend_q, edge_q;
  logic [IN_COUNT-1:0] ie_nxt, pend_nxt, edge_nxt, evt;
  logic                irq_q;

  assign evt = (in_nxt & ~in_q & edge_q) | (~in_nxt & in_q & ~edge_q);

  always_comb begin
    ie_nxt   = ie_q;
    pend_nxt = pend_q;
    edge_nxt = edge_q;
    if (|modify) begin
      case (off)
        12'd2:   ie_nxt   = IN_COUNT'(apply_mod(32'(ie_q), wdata, modify));
        12'd3:   pend_nxt = IN_COUNT'(apply_mod(32'(pend_q), wdata, modify));
        12'd4:   edge_nxt = IN_COUNT'(apply_mod(32'(edge_q), wdata, modify));
        default: ;
      endcase
    end
    // A hardware event outranks a software clear of the same bit.
    pend_nxt = pend_nxt | evt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ie_q   <= '0;
      pend_q <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ie_q   <= ie_nxt;
      pend_q <= pend_nxt;
      edge_q <= edge_nxt;
      irq_q  <= |(pend_q & ie_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    hit    = 1'b0;
    rd_hit = '0;
    case (off)
      12'd0: begin hit = 1'b1; rd_hit = 32'(out_q);  end
      12'd1: begin hit = 1'b1; rd_hit = 32'(in_q);   end
`ifdef GPIO_IRQ_EN
      12'd2: begin hit = 1'b1; rd_hit = 32'(ie_q);   end
      12'd3: begin hit = 1'b1; rd_hit = 32'(pend_q); end
      12'd4: begin hit = 1'b1; rd_hit = 32'(edge_q); end
`endif
      default: ;
    endcase
  end

  assign valid = hit & access;
  assign rdata = rd_hit;

endmodule

// File: tb/tb_csr_gpio_bank.sv
// Bench for csr_gpio_bank: CSR vector table plus debounce/irq/reset sequences.
module tb_csr_gpio_bank;

  localparam logic [11:0] BASE = 12'hBC4;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'b000;
  logic [31:0] wdata = 32'h0;
  logic [11:0] addr = 12'h0;
  logic [31:0] rdata;
  logic        valid;
  logic [3:0]  inpins = 4'h0;
  logic [3:0]  outpins;
  logic        irq;

  always #5 clk = ~clk;

  csr_gpio_bank #(
    .IN_COUNT (4),
    .OUT_COUNT(4),
    .BASE_ADDR(BASE),
    .TICK_DIV (4),
    .OUT_RESET(32'hA)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .inpins (inpins),
    .outpins(outpins),
    .irq    (irq)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        vld;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        rd;
    logic [2:0]  mod;
    logic [31:0] wd;
    logic [11:0] addr;
    logic        exp_vld;
    logic [31:0] exp_rd;
    logic [3:0]  exp_out;
  } vec_t;
  vec_t vecs[16];

  function automatic vec_t mk(input logic rd, input logic [2:0] m, input logic [31:0] wd,
                              input logic [11:0] a, input logic ev, input logic [31:0] er,
                              input logic [3:0] eo);
    vec_t v;
    v.rd = rd; v.mod = m; v.wd = wd; v.addr = a;
    v.exp_vld = ev; v.exp_rd = er; v.exp_out = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 after the update edge.
  task automatic access(input string name, input logic rd, input logic [2:0] m,
                        input logic [31:0] wd, input logic [11:0] a,
                        input logic ev, input logic [31:0] er);
    exp_t e;
    exp_t got;
    read = rd; modify = m; wdata = wd; addr = a;
    e.vld = ev; e.rd = er;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    check({name, ".valid"}, 32'(valid), 32'(got.vld));
    check({name, ".rdata"}, rdata, got.rd);
    @(posedge clk); #1;
    read = 1'b0; modify = 3'b000; wdata = 32'h0;
  endtask

  // Reads one register each cycle until it equals tgt; edges = -1 on timeout.
  task automatic poll(input logic [11:0] a, input logic [31:0] tgt, input int max_edges,
                      output int edges);
    edges = -1;
    read = 1'b1; addr = a;
    for (int i = 0; i <= max_edges; i++) begin
      #1;
      if (rdata == tgt) begin
        edges = i;
        break;
      end
      @(posedge clk);
    end
    read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    vecs[0]  = mk(1, 3'b000, 32'h0,         BASE + 12'd0, 1,   32'hA, 4'hA);
    vecs[1]  = mk(1, 3'b000, 32'h0,         12'hBC9,      0,   32'h0, 4'hA);
    vecs[2]  = mk(0, 3'b001, 32'hFFFF_FFF5, BASE + 12'd0, 1,   32'hA, 4'h5);
    vecs[3]  = mk(0, 3'b100, 32'h1,         BASE + 12'd0, 1,   32'h5, 4'h4);
    vecs[4]  = mk(1, 3'b000, 32'h0,         BASE + 12'd0, 1,   32'h4, 4'h4);
    vecs[5]  = mk(0, 3'b010, 32'h3,         BASE + 12'd0, 1,   32'h4, 4'h7);
    vecs[6]  = mk(0, 3'b001, 32'hF,         BASE + 12'd1, 1,   32'h0, 4'h7);
    vecs[7]  = mk(1, 3'b000, 32'h0,         BASE + 12'd1, 1,   32'h0, 4'h7);
    vecs[8]  = mk(1, 3'b000, 32'h0,         12'hBC3,      0,   32'h0, 4'h7);
    vecs[9]  = mk(1, 3'b000, 32'h0,         BASE + 12'd2, IRQ, 32'h0, 4'h7);
    vecs[10] = mk(0, 3'b001, 32'hFF,        BASE + 12'd2, IRQ, 32'h0, 4'h7);
    vecs[11] = mk(1, 3'b000, 32'h0,         BASE + 12'd2, IRQ, IRQ ? 32'hF : 32'h0, 4'h7);
    vecs[12] = mk(0, 3'b001, 32'h0,         BASE + 12'd2, IRQ, IRQ ? 32'hF : 32'h0, 4'h7);
    vecs[13] = mk(1, 3'b000, 32'h0,         BASE + 12'd4, IRQ, 32'h0, 4'h7);
    vecs[14] = mk(0, 3'b001, 32'h0,         BASE + 12'd0, 1,   32'h7, 4'h0);
    vecs[15] = mk(0, 3'b100, 32'h0,         12'hBC9,      0,   32'h0, 4'h0);

    // Reset state
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outpins", 32'(outpins), 32'hA);
    check("rst_irq", 32'(irq), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_outpins", 32'(outpins), 32'hA);
    check("rel_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 16; i++) begin
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].mod, vecs[i].wd, vecs[i].addr,
             vecs[i].exp_vld, vecs[i].exp_rd);
      check($sformatf("vec%0d.outpins", i), 32'(outpins), 32'(vecs[i].exp_out));
    end

`ifdef GPIO_IRQ_EN
    access("edge_wr", 0, 3'b001, 32'h1, BASE + 12'd4, 1, 32'h0);
    access("ie_wr",   0, 3'b001, 32'h1, BASE + 12'd2, 1, 32'h0);
`endif

    // Steady input: debounced value (and, with irqs, PEND) within 14 cycles
    inpins = 4'h1;
    poll(IRQ ? BASE + 12'd3 : BASE + 12'd1, 32'h1, 14, edges);
    check("in_latency_ok", 32'(edges >= 0), 32'h1);
`ifdef GPIO_IRQ_EN
    check("irq_lag", 32'(irq), 32'h0);
    @(posedge clk); #1;
    check("irq_rise", 32'(irq), 32'h1);
`endif
    access("in_rd", 1, 3'b000, 32'h0, BASE + 12'd1, 1, 32'h1);
`ifdef GPIO_IRQ_EN
    access("pend_clr", 0, 3'b100, 32'h1, BASE + 12'd3, 1, 32'h1);
    @(posedge clk); #1;
    check("irq_fall", 32'(irq), 32'h0);
`endif

    // Single-cycle glitch never accumulates three equal samples
    inpins = 4'h5;
    @(posedge clk); #1;
    inpins = 4'h1;
    repeat (16) @(posedge clk);
    #1;
    access("glitch_in", 1, 3'b000, 32'h0, BASE + 12'd1, 1, 32'h1);
`ifdef GPIO_IRQ_EN
    access("glitch_pend", 1, 3'b000, 32'h0, BASE + 12'd3, 1, 32'h0);

    // Falling edge (no event with EDGE=1) locates a tick; rising update lands 12 edges later
    inpins = 4'h0;
    poll(BASE + 12'd1, 32'h0, 16, edges);
    check("fall_seen", 32'(edges >= 0), 32'h1);
    inpins = 4'h1;
    repeat (11) @(posedge clk);
    #1;
    access("clr_vs_evt", 0, 3'b100, 32'h1, BASE + 12'd3, 1, 32'h0);
    access("pend_kept", 1, 3'b000, 32'h0, BASE + 12'd3, 1, 32'h1);
    check("irq_after_evt", 32'(irq), 32'h1);
`else
    check("irq_tied", 32'(irq), 32'h0);
`endif

    // Reset mid-debounce discards history
    rstn = 1'b0;
    inpins = 4'h8;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    access("mid_in", 1, 3'b000, 32'h0, BASE + 12'd1, 1, 32'h0);
    rstn = 1'b0;
    #1;
    check("mid_rst_out", 32'(outpins), 32'hA);
    check("mid_rst_irq", 32'(irq), 32'h0);
    access("mid_rst_in", 1, 3'b000, 32'h0, BASE + 12'd1, 1, 32'h0);
    rstn = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    access("post_rst_in11", 1, 3'b000, 32'h0, BASE + 12'd1, 1, 32'h0);
    access("post_rst_in12", 1, 3'b000, 32'h0, BASE + 12'd1, 1, 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
